i2s_clkgen: RTL

Parametrised, single-clock I2S/TDM clock generator, successor to the fixed-ratio divider. From `pclk` it produces `mclk`, `sclk` and `ws` as registered outputs, plus one-cycle edge strobes for the serializer/deserializer. It supports:
- integer+fractional `mclk` division;
- programmable `sclk` ratio, slot length and channel count (mono, stereo or TDM up to `MAX_CH`);
- shadowed reconfiguration applied only at frame boundaries.

It sits between the register block (`OP`/config) and the transmit/receive data paths.

---
 rtl/ctrl_pkg.sv | 27 ++
 rtl/i2s_frac_div.sv | 44 ++++
 rtl/i2s_clkgen.sv | 109 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared config type, reset defaults and sclk-ratio helpers for i2s_clkgen.
package ctrl_pkg;
  localparam int CLK_DIV_W  = 8;
  localparam int CLK_FRAC_W = 8;
  localparam int CLK_MAX_CH = 8;
  localparam int CLK_CH_W   = $clog2(CLK_MAX_CH + 1);
  typedef enum logic [1:0] {SCLK_R2, SCLK_R4, SCLK_R8, SCLK_R16} sclk_sel_e;
  typedef struct packed {
    logic [CLK_DIV_W-1:0]  div;
    logic [CLK_FRAC_W-1:0] frac;
    sclk_sel_e             sclk_sel;
    logic                  slot32;
    logic [CLK_CH_W-1:0]   nch;
  } clkgen_cfg_t;
  localparam clkgen_cfg_t CFG_RST = '{
    div: CLK_DIV_W'(2), frac: '0, sclk_sel: SCLK_R2, slot32: 1'b0, nch: CLK_CH_W'(2)
  };
  function automatic logic [3:0] r_last(input sclk_sel_e s);
    return 4'hf >> ~s;
  endfunction
  function automatic logic [3:0] r_half(input sclk_sel_e s);
    return 4'd1 << s;
  endfunction
  function automatic logic [4:0] l_last(input logic slot32);
    return slot32 ? 5'd31 : 5'd15;
  endfunction
endpackage

// File: rtl/i2s_frac_div.sv
// i2s_frac_div: N + F/2^FRAC_W mclk divider; tick marks the last pclk cycle of each mclk period.
module i2s_frac_div #(
  parameter int DIV_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic              pclk,
  input  logic              rst_,
  input  logic              clr,
  input  logic              start,
  input  logic [DIV_W-1:0]  n,
  input  logic [FRAC_W-1:0] f,
  output logic              mclk,
  output logic              tick
);
  localparam logic [DIV_W:0] ONE = (DIV_W + 1)'(1);
  logic [DIV_W:0]  per_q, per_d, cyc_q, cyc_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0] sum;
  logic mclk_q, mclk_d, newp;
  always_comb begin
    tick   = cyc_q == per_q - ONE;
    newp   = start || tick;
    sum    = {1'b0, start ? FRAC_W'(0) : acc_q} + {1'b0, f};
    per_d  = clr ? '0 : newp ? {1'b0, n} + {{DIV_W{1'b0}}, sum[FRAC_W]} : per_q;
    acc_d  = clr ? '0 : newp ? sum[FRAC_W-1:0] : acc_q;
    cyc_d  = (clr || newp) ? '0 : cyc_q + ONE;
    // high for ceil(P/2) cycles, so odd periods favour the high phase
    mclk_d = !clr && (cyc_d < ((per_d + ONE) >> 1));
  end
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      per_q  <= '0;
      cyc_q  <= '0;
      acc_q  <= '0;
      mclk_q <= 1'b0;
    end else begin
      per_q  <= per_d;
      cyc_q  <= cyc_d;
      acc_q  <= acc_d;
      mclk_q <= mclk_d;
    end
  end
  assign mclk = mclk_q;
endmodule

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: mclk/sclk/ws generator for I2S and TDM framing with frame-boundary shadowed reconfiguration.
module i2s_clkgen
  import ctrl_pkg::*;
#(
  parameter int DIV_W  = CLK_DIV_W,
  parameter int FRAC_W = CLK_FRAC_W,
  parameter int MAX_CH = CLK_MAX_CH,
  parameter int CH_W   = $clog2(MAX_CH + 1)
) (
  input  logic              pclk,
  input  logic              rst_,
  input  logic              en,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic [1:0]        cfg_sclk_sel,
  input  logic              cfg_slot32,
  input  logic [CH_W-1:0]   cfg_nch,
  output logic              mclk,
  output logic              sclk,
  output logic              ws,
  output logic              sclk_fall,
  output logic              sclk_rise,
  output logic              frame_start,
  output logic              cfg_pend
);
  function automatic logic [DIV_W-1:0] div_eff(input logic [DIV_W-1:0] d);
    return d < DIV_W'(2) ? DIV_W'(2) : d;
  endfunction
  function automatic logic [CH_W-1:0] nch_eff(input logic [CH_W-1:0] c);
    return c == '0 ? CH_W'(1) : c > CH_W'(MAX_CH) ? CH_W'(MAX_CH) : c;
  endfunction
  clkgen_cfg_t cfg_q, cfg_d, shd_q, shd_d, cfg_in;
  logic pend_q, pend_d, run_q, run_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [4:0] bit_q, bit_d;
  logic [CH_W-1:0] slot_q, slot_d;
  logic sclk_q, sclk_d, ws_q, ws_d, fall_q, fall_d, rise_q, rise_d, fs_q, fs_d;
  logic start, tick, adv, mwrap, bwrap, swrap, bnd, apply;
  i2s_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_div (
    .pclk  (pclk),
    .rst_  (rst_),
    .clr   (!en),
    .start (start),
    .n     (div_eff(cfg_d.div)),
    .f     (cfg_d.frac),
    .mclk  (mclk),
    .tick  (tick)
  );
  always_comb begin
    cfg_in = '{div: cfg_div, frac: cfg_frac, sclk_sel: sclk_sel_e'(cfg_sclk_sel),
               slot32: cfg_slot32, nch: cfg_nch};
    start  = en && !run_q;
    adv    = en && run_q && tick;
    mwrap  = mcnt_q == r_last(cfg_q.sclk_sel);
    bwrap  = bit_q == l_last(cfg_q.slot32);
    swrap  = slot_q == nch_eff(cfg_q.nch) - CH_W'(1);
    bnd    = start || (adv && mwrap && bwrap && swrap);
    // the shadow lands at a frame boundary, or immediately while stopped
    apply  = pend_q && (bnd || !en);
    cfg_d  = apply ? shd_q : cfg_q;
    shd_d  = cfg_load ? cfg_in : shd_q;
    pend_d = cfg_load || (pend_q && !apply);
    run_d  = en;
    mcnt_d = (!en || bnd) ? '0 : adv ? (mwrap ? '0 : mcnt_q + 4'd1) : mcnt_q;
    bit_d  = (!en || bnd) ? '0 : (adv && mwrap) ? (bwrap ? '0 : bit_q + 5'd1) : bit_q;
    slot_d = (!en || bnd) ? '0 : (adv && mwrap && bwrap) ? slot_q + CH_W'(1) : slot_q;
    sclk_d = mcnt_d >= r_half(cfg_d.sclk_sel);
    fall_d = (start || adv) && mcnt_d == '0;
    rise_d = (start || adv) && mcnt_d == r_half(cfg_d.sclk_sel);
    fs_d   = bnd;
    ws_d   = en && (nch_eff(cfg_d.nch) == CH_W'(2) ? slot_d[0] : (slot_d == '0 && bit_d == '0));
  end
  always_ff @(posedge pclk or negedge rst_) begin
    if (!rst_) begin
      cfg_q  <= CFG_RST;
      shd_q  <= '0;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      mcnt_q <= '0;
      bit_q  <= '0;
      slot_q <= '0;
      sclk_q <= 1'b0;
      ws_q   <= 1'b0;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      mcnt_q <= mcnt_d;
      bit_q  <= bit_d;
      slot_q <= slot_d;
      sclk_q <= sclk_d;
      ws_q   <= ws_d;
      fall_q <= fall_d;
      rise_q <= rise_d;
      fs_q   <= fs_d;
    end
  end
  assign sclk        = sclk_q;
  assign ws          = ws_q;
  assign sclk_fall   = fall_q;
  assign sclk_rise   = rise_q;
  assign frame_start = fs_q;
  assign cfg_pend    = pend_q;
endmodule
